// File: rtl/alu16_sequencer.sv
// Two-pass (low byte, then high byte) Z80 16-bit arithmetic controller: ADD/ADC/SBC/INC/DEC rr.
// Optional ALU16_SEQ_FAST_INCDEC_EN: carry-free INC/DEC finish after the low pass.
module alu16_sequencer #(
   parameter int lane_width = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [2:0]              op,
   input  logic [2*lane_width-1:0] a,
   input  logic [2*lane_width-1:0] b,
   input  logic [7:0]              flags_in,
   output logic                    busy,
   output logic                    done,
   output logic [2*lane_width-1:0] result,
   output logic [7:0]              flags_out
);

   localparam int W = 2 * lane_width;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LO   = 2'd1;
   localparam logic [1:0] S_HI   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SBC = 3'd2;
   localparam logic [2:0] OP_INC = 3'd3;
   localparam logic [2:0] OP_DEC = 3'd4;

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [W-1:0]          a_q;
   logic [W-1:0]          b_q;
   logic [2:0]            op_q;
   logic [7:0]            f_q;
   logic [lane_width-1:0] lo_q;
   logic                  lane_c_q;
   logic                  lo_zero_q;

   logic                  accept;
   logic                  illegal_in;
   logic                  is_incdec;
   logic                  is_carry_op;
   logic                  lane_sub;
   logic [lane_width-1:0] lane_x;
   logic [lane_width-1:0] lane_y;
   logic [lane_width-1:0] lane_y_eff;
   logic                  lane_cin;
   logic                  lane_c_eff;
   logic [lane_width-1:0] lane_sum;
   logic                  lane_raw_cout;
   logic                  lane_cout;
   logic                  lane_half;
   logic                  lane_ovf;
   logic                  fast_skip;
   logic [7:0]            hi_flags;

   assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
   assign illegal_in  = (op > OP_DEC);
   assign is_incdec   = (op_q == OP_INC) || (op_q == OP_DEC);
   assign is_carry_op = (op_q == OP_ADC) || (op_q == OP_SBC);

   // Shared lane adder: subtraction is x + ~y + ~borrow, with carry/half
   // re-inverted afterwards so lane_cout/lane_half always mean "carry" for
   // adds and "borrow" for subtracts.
   always_comb begin
      lane_sub   = (op_q == OP_SBC) || (op_q == OP_DEC);
      lane_x     = '0;
      lane_y     = '0;
      lane_cin   = 1'b0;
      if (state == S_HI) begin
         lane_x   = a_q[W-1:lane_width];
         lane_y   = is_incdec ? '0 : b_q[W-1:lane_width];
         lane_cin = lane_c_q;
      end else begin
         lane_x   = a_q[lane_width-1:0];
         lane_y   = is_incdec ? {{(lane_width-1){1'b0}}, 1'b1} : b_q[lane_width-1:0];
         lane_cin = is_carry_op ? f_q[0] : 1'b0;
      end
      lane_y_eff = lane_sub ? ~lane_y : lane_y;
      lane_c_eff = lane_cin ^ lane_sub;
      {lane_raw_cout, lane_sum} = {1'b0, lane_x} + {1'b0, lane_y_eff}
                                + {{lane_width{1'b0}}, lane_c_eff};
      lane_cout  = lane_raw_cout ^ lane_sub;
      lane_half  = (lane_sum[4] ^ lane_x[4] ^ lane_y_eff[4]) ^ lane_sub;
      if (lane_sub)
         lane_ovf = (lane_x[lane_width-1] != lane_y[lane_width-1])
                 && (lane_sum[lane_width-1] != lane_x[lane_width-1]);
      else
         lane_ovf = (lane_x[lane_width-1] == lane_y[lane_width-1])
                 && (lane_sum[lane_width-1] != lane_x[lane_width-1]);
   end

   // Final F for the high pass; S/Z/PV survive from the old F on plain ADD.
   always_comb begin
      hi_flags = f_q;
      case (op_q)
         OP_ADD: hi_flags = {f_q[7], f_q[6], lane_sum[lane_width-3], lane_half,
                             lane_sum[lane_width-5], f_q[2], 1'b0, lane_cout};
         OP_ADC,
         OP_SBC: hi_flags = {lane_sum[lane_width-1], lo_zero_q && (lane_sum == '0),
                             lane_sum[lane_width-3], lane_half, lane_sum[lane_width-5],
                             lane_ovf, lane_sub, lane_cout};
         default: hi_flags = f_q;
      endcase
   end

`ifdef ALU16_SEQ_FAST_INCDEC_EN
   assign fast_skip = (state == S_LO) && is_incdec && !lane_cout;
`else
   assign fast_skip = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE,
         S_DONE: begin
            if (accept)
               state_next = illegal_in ? S_DONE : S_LO;
            else
               state_next = S_IDLE;
         end
         S_LO:    state_next = fast_skip ? S_DONE : S_HI;
         S_HI:    state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   // All outputs are registered from the next-state decision so done/busy
   // line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         flags_out <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         f_q       <= '0;
         lo_q      <= '0;
         lane_c_q  <= 1'b0;
         lo_zero_q <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == S_LO) || (state_next == S_HI);
         done  <= (state_next == S_DONE);
         if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            f_q  <= flags_in;
            if (illegal_in) begin
               result    <= a;
               flags_out <= flags_in;
            end
         end else if (state == S_LO) begin
            lo_q      <= lane_sum;
            lane_c_q  <= lane_cout;
            lo_zero_q <= (lane_sum == '0);
            if (fast_skip) begin
               result    <= {a_q[W-1:lane_width], lane_sum};
               flags_out <= f_q;
            end
         end else if (state == S_HI) begin
            result    <= {lane_sum, lo_q};
            flags_out <= hi_flags;
         end
      end
   end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomized self-checking bench for alu16_sequencer against an arithmetic reference model.
// Honors ALU16_SEQ_FAST_INCDEC_EN when computing expected latency.
module tb_alu16_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic [7:0]  flags_in = 8'h0;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [7:0]  flags_out;

   int checks = 0;
   int errors = 0;

   alu16_sequencer #(.lane_width(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .flags_in(flags_in), .busy(busy), .done(done), .result(result),
      .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Reference model from the Z80 flag rules using plain integer arithmetic.
   function automatic void model(input logic [2:0] m_op, input logic [15:0] x,
                                 input logic [15:0] y, input logic [7:0] f,
                                 output logic [15:0] r, output logic [7:0] nf,
                                 output int lat);
      int s, h, sv, ci;
      logic v;
      ci  = int'(f[0]);
      lat = 3;
      nf  = f;
      r   = x;
      case (m_op)
         3'd0: begin
            s  = int'(x) + int'(y);
            h  = int'(x & 16'h0FFF) + int'(y & 16'h0FFF);
            r  = s[15:0];
            nf = {f[7], f[6], r[13], h > 4095, r[11], f[2], 1'b0, s > 65535};
         end
         3'd1: begin
            s  = int'(x) + int'(y) + ci;
            h  = int'(x & 16'h0FFF) + int'(y & 16'h0FFF) + ci;
            sv = int'($signed(x)) + int'($signed(y)) + ci;
            v  = (sv > 32767) || (sv < -32768);
            r  = s[15:0];
            nf = {r[15], r == 16'h0, r[13], h > 4095, r[11], v, 1'b0, s > 65535};
         end
         3'd2: begin
            s  = int'(x) - int'(y) - ci;
            h  = int'(x & 16'h0FFF) - int'(y & 16'h0FFF) - ci;
            sv = int'($signed(x)) - int'($signed(y)) - ci;
            v  = (sv > 32767) || (sv < -32768);
            r  = s[15:0];
            nf = {r[15], r == 16'h0, r[13], h < 0, r[11], v, 1'b1, s < 0};
         end
         3'd3: begin
            r = x + 16'd1;
`ifdef ALU16_SEQ_FAST_INCDEC_EN
            if (x[7:0] != 8'hFF) lat = 2;
`endif
         end
         3'd4: begin
            r = x - 16'd1;
`ifdef ALU16_SEQ_FAST_INCDEC_EN
            if (x[7:0] != 8'h00) lat = 2;
`endif
         end
         default: lat = 1;
      endcase
   endfunction

   // Issue one operation from IDLE, scramble the inputs afterwards, and
   // check busy per cycle, done latency, outputs and the single-cycle pulse.
   task automatic applyStimulus(input logic [2:0] s_op, input logic [15:0] s_a,
                                input logic [15:0] s_b, input logic [7:0] s_f);
      logic [15:0] exp_r;
      logic [7:0]  exp_f;
      int          lat;
      int          n;
      model(s_op, s_a, s_b, s_f, exp_r, exp_f, lat);
      @(negedge clk);
      start = 1'b1; op = s_op; a = s_a; b = s_b; flags_in = s_f;
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
      flags_in = 8'($urandom);
      n = 1;
      while (n <= 8 && !done) begin
         checkOutput("busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
         n++;
      end
      checkOutput("latency", n, lat);
      checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
      checkOutput("result", {16'd0, result}, {16'd0, exp_r});
      checkOutput("flags", {24'd0, flags_out}, {24'd0, exp_f});
      @(negedge clk);
      checkOutput("done_pulse", {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] exp_r;
      logic [7:0]  exp_f;
      int          lat;
      int          pulses;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_result", {16'd0, result}, 32'd0);
      checkOutput("reset_flags", {24'd0, flags_out}, 32'd0);
      reset_n = 1'b1;

      applyStimulus(3'd0, 16'h0FFF, 16'h0001, 8'hFF);
      applyStimulus(3'd1, 16'h7FFF, 16'h0000, 8'h01);
      applyStimulus(3'd2, 16'hABCD, 16'hABCD, 8'h00);
      applyStimulus(3'd2, 16'h0000, 16'h0001, 8'h00);
      applyStimulus(3'd3, 16'hFFFF, 16'h1234, 8'h5A);
      applyStimulus(3'd4, 16'h0000, 16'h1234, 8'h5A);
      applyStimulus(3'd3, 16'hABCD, 16'h0000, 8'hA5);
      applyStimulus(3'd3, 16'h00FF, 16'h0000, 8'hA5);
      applyStimulus(3'd4, 16'h0100, 16'h0000, 8'h3C);
      applyStimulus(3'd6, 16'hBEEF, 16'h1111, 8'h77);

      // Back-to-back: start held for 9 edges, inputs scrambled while busy.
      model(3'd0, 16'h1234, 16'h4321, 8'h00, exp_r, exp_f, lat);
      pulses = 0;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 16'h1234; b = 16'h4321; flags_in = 8'h00;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            checkOutput("b2b_result", {16'd0, result}, {16'd0, exp_r});
            checkOutput("b2b_flags", {24'd0, flags_out}, {24'd0, exp_f});
         end
         if (busy) begin
            op = 3'd2; a = 16'($urandom); b = 16'($urandom); flags_in = 8'($urandom);
         end else begin
            op = 3'd0; a = 16'h1234; b = 16'h4321; flags_in = 8'h00;
         end
      end
      start = 1'b0;
      checkOutput("b2b_pulses", pulses, 3);
      repeat (2) @(negedge clk);

      // Asynchronous reset during the HI pass.
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 16'h5555; b = 16'h2222; flags_in = 8'h01;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_hi_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_hi_done", {31'd0, done}, 32'd0);
      checkOutput("rst_hi_result", {16'd0, result}, 32'd0);
      checkOutput("rst_hi_flags", {24'd0, flags_out}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checkOutput("rst_no_done", pulses, 0);
      applyStimulus(3'd0, 16'h8000, 16'h8000, 8'h00);

      // Random operations with some boundary-heavy operands.
      for (int i = 0; i < 200; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (($urandom % 4) == 0) ra = (($urandom % 2) == 0) ? 16'hFFFF : 16'h0000;
         if (($urandom % 4) == 0) ra[7:0] = (($urandom % 2) == 0) ? 8'hFF : 8'h00;
         applyStimulus(3'($urandom_range(0, 7)), ra, rb, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
